// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: sequences one shared combinational ALU between two valid/ready requesters.
// Define ALU_SHARE_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module alu_share_ctrl #(
  parameter int DW_IN  = 4,
  parameter int SEL_W  = 4,
  parameter int DW_OUT = 8,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DW_IN-1:0]  req0_a,
  input  logic [DW_IN-1:0]  req0_b,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DW_IN-1:0]  req1_a,
  input  logic [DW_IN-1:0]  req1_b,
  input  logic [SEL_W-1:0]  req1_sel,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DW_OUT-1:0] rsp0_y,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DW_OUT-1:0] rsp1_y,
  output logic [DW_IN-1:0]  alu_a,
  output logic [DW_IN-1:0]  alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DW_OUT-1:0] alu_y,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  localparam logic [2:0] CNT_LOAD = 3'(SETTLE - 1);

  state_t            state, state_nxt;
  logic [2:0]        cnt;
  logic [DW_OUT-1:0] result;
  logic              win1;
  logic              accept;
  logic              rsp_ready;

`ifdef ALU_SHARE_FIXED_PRIO_EN
  assign win1 = req1_valid & ~req0_valid;
`else
  logic last_grant;

  // A tie goes to whichever requester was not served last.
  assign win1 = req1_valid & (~req0_valid | ~last_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_grant <= 1'b1;
    else if (accept)
      last_grant <= win1;
  end
`endif

  assign req0_ready = (state == IDLE) & req0_valid & ~win1;
  assign req1_ready = (state == IDLE) & win1;
  assign accept     = req0_ready | req1_ready;
  assign rsp_ready  = grant_id ? rsp1_ready : rsp0_ready;

  assign busy       = (state != IDLE);
  assign rsp0_valid = (state == RESP) & ~grant_id;
  assign rsp1_valid = (state == RESP) & grant_id;
  assign rsp0_y     = result;
  assign rsp1_y     = result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = EXEC;
      EXEC: if (cnt == 3'd0) state_nxt = CAPT;
      CAPT: state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands stay registered after completion so the ALU inputs never glitch back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 3'd0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= '0;
      grant_id <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a    <= win1 ? req1_a : req0_a;
            alu_b    <= win1 ? req1_b : req0_b;
            alu_sel  <= win1 ? req1_sel : req0_sel;
            grant_id <= win1;
            cnt      <= CNT_LOAD;
          end
        end
        EXEC: if (cnt != 3'd0) cnt <= cnt - 3'd1;
        CAPT: result <= alu_y;
        default: ;
      endcase
    end
  end

endmodule
